// File: rtl/router_pkg.sv
// router_pkg: shared widths and header field layout for the router datapath
package router_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 1;
  localparam int LEN_LSB = 2;
  localparam int LEN_MSB = 7;
  localparam logic [ADDR_MSB:ADDR_LSB] ADDR_INVALID = 2'b11;
  function automatic logic addr_ok(input logic [DATA_WIDTH-1:0] b);
    return b[ADDR_MSB:ADDR_LSB] != ADDR_INVALID;
  endfunction
  function automatic logic [LEN_MSB-LEN_LSB:0] hdr_len(input logic [DATA_WIDTH-1:0] b);
    return b[LEN_MSB:LEN_LSB];
  endfunction
endpackage

// File: rtl/router_reg_if.sv
// router_reg_if: FSM strobes, source byte and FIFO-side outputs of router_reg (err_cnt under ROUTER_REG_ERR_CNT_EN)
interface router_reg_if #(parameter int DATA_WIDTH = router_pkg::DATA_WIDTH);
  logic packet_valid, fifo_full;
  logic detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic parity_done, low_packet_valid, err;
  logic [DATA_WIDTH-1:0] datain, dout;
`ifdef ROUTER_REG_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif
  modport master (
    output packet_valid, fifo_full, datain, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    input dout, parity_done, low_packet_valid, err
`ifdef ROUTER_REG_ERR_CNT_EN
    , err_cnt
`endif
  );
  modport slave (
    input packet_valid, fifo_full, datain, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_packet_valid, err
`ifdef ROUTER_REG_ERR_CNT_EN
    , err_cnt
`endif
  );
endinterface

// File: rtl/router_parity_acc.sv
// router_parity_acc: running payload parity, captured parity byte and their compare
module router_parity_acc #(parameter int DATA_WIDTH = router_pkg::DATA_WIDTH) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clr,
  input  logic                  acc_en,
  input  logic [DATA_WIDTH-1:0] acc_data,
  input  logic                  cap_en,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  chk,
  output logic                  err
);
  logic [DATA_WIDTH-1:0] int_parity, pkt_parity;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      int_parity <= '0;
      pkt_parity <= '0;
      err <= 1'b0;
    end else begin
      int_parity <= clr ? '0 : acc_en ? int_parity ^ acc_data : int_parity;
      pkt_parity <= clr ? '0 : cap_en ? cap_data : pkt_parity;
      err <= clr ? 1'b0 : chk ? int_parity != pkt_parity : err;
    end
endmodule

// File: rtl/router_reg.sv
// router_reg: router datapath register stage; ROUTER_REG_ERR_CNT_EN adds a saturating err_cnt
module router_reg #(parameter int DATA_WIDTH = router_pkg::DATA_WIDTH) (
  input logic       clk,
  input logic       resetn,
  router_reg_if.slave bus
);
  import router_pkg::*;
  logic [DATA_WIDTH-1:0] header_byte, ffs_byte;
  logic pd_q, pd_set, acc_en, cap_en;
  assign pd_set = (bus.ld_state & ~bus.fifo_full & ~bus.packet_valid) |
                  (bus.laf_state & bus.low_packet_valid & ~bus.parity_done);
  assign acc_en = bus.lfd_state | (bus.ld_state & bus.packet_valid & ~bus.full_state);
  assign cap_en = bus.ld_state & ~bus.packet_valid & ~bus.fifo_full;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      header_byte <= '0;
      ffs_byte <= '0;
      bus.dout <= '0;
      bus.parity_done <= 1'b0;
      bus.low_packet_valid <= 1'b0;
      pd_q <= 1'b0;
    end else begin
      if (bus.detect_add && bus.packet_valid && addr_ok(bus.datain)) header_byte <= bus.datain;
      if (bus.ld_state && bus.fifo_full) ffs_byte <= bus.datain;
      bus.dout <= bus.lfd_state ? header_byte :
                  (bus.ld_state && !bus.fifo_full) ? bus.datain :
                  bus.laf_state ? ffs_byte : bus.dout;
      bus.parity_done <= pd_set | (bus.parity_done & ~bus.detect_add);
      bus.low_packet_valid <= (bus.ld_state & ~bus.packet_valid) | (bus.low_packet_valid & ~bus.rst_int_reg);
      pd_q <= bus.parity_done;
    end
  router_parity_acc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
    .clk(clk),
    .resetn(resetn),
    .clr(bus.detect_add),
    .acc_en(acc_en),
    .acc_data(bus.lfd_state ? header_byte : bus.datain),
    .cap_en(cap_en),
    .cap_data(bus.datain),
    .chk(bus.parity_done & ~pd_q),
    .err(bus.err)
  );
`ifdef ROUTER_REG_ERR_CNT_EN
  logic err_d;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      err_d <= 1'b0;
      bus.err_cnt <= '0;
    end else begin
      err_d <= bus.err;
      if (bus.err && !err_d && bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: directed packets checked every cycle against a packet-level parity model
module tb_router_reg;
  logic clk, resetn;
  router_reg_if #(.DATA_WIDTH(8)) bus ();
  router_reg #(.DATA_WIDTH(8)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] m_hdr, m_dout, m_held, m_par, m_cnt;
  logic [7:0] m_q[$];
  logic m_pd, m_pd_old, m_lpv, m_err, m_err_old;
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] xsum();
    logic [7:0] x = 8'h00;
    foreach (m_q[i]) x ^= m_q[i];
    return x;
  endfunction
  task automatic m_reset();
    m_hdr = 0; m_dout = 0; m_held = 0; m_par = 0; m_cnt = 0;
    m_q.delete();
    m_pd = 0; m_pd_old = 0; m_lpv = 0; m_err = 0; m_err_old = 0;
  endtask
  task automatic model_update();
    logic pd_rise, err_rise;
    if (!resetn) begin
      m_reset();
      return;
    end
    pd_rise = m_pd && !m_pd_old;
    err_rise = m_err && !m_err_old;
    m_pd_old = m_pd;
    m_err_old = m_err;
    if (err_rise && m_cnt != 8'hFF) m_cnt++;
    if (pd_rise) m_err = xsum() != m_par;
    if (bus.detect_add) begin
      if (bus.packet_valid && bus.datain[1:0] != 2'b11) m_hdr = bus.datain;
      m_q.delete();
      m_par = 0; m_err = 0; m_pd = 0;
    end
    if (bus.lfd_state) begin
      m_q.push_back(m_hdr);
      m_dout = m_hdr;
    end
    if (bus.ld_state) begin
      if (bus.packet_valid) m_q.push_back(bus.datain);
      if (!bus.fifo_full) m_dout = bus.datain;
      else m_held = bus.datain;
      if (!bus.packet_valid) begin
        m_lpv = 1;
        if (!bus.fifo_full) begin
          m_par = bus.datain;
          m_pd = 1;
        end
      end
    end
    if (bus.laf_state) begin
      m_dout = m_held;
      if (m_lpv && !m_pd) m_pd = 1;
    end
    if (bus.rst_int_reg) m_lpv = 0;
  endtask
  task automatic compare_all();
    check("dout", bus.dout, m_dout);
    check("parity_done", {7'd0, bus.parity_done}, {7'd0, m_pd});
    check("low_packet_valid", {7'd0, bus.low_packet_valid}, {7'd0, m_lpv});
    check("err", {7'd0, bus.err}, {7'd0, m_err});
`ifdef ROUTER_REG_ERR_CNT_EN
    check("err_cnt", bus.err_cnt, m_cnt);
`endif
  endtask
  task automatic drive(input string st, input logic [7:0] d, input logic pv, input logic ff);
    bus.detect_add = st == "det";
    bus.lfd_state = st == "lfd";
    bus.ld_state = st == "ld";
    bus.laf_state = st == "laf";
    bus.full_state = st == "full";
    bus.rst_int_reg = st == "chk";
    bus.datain = d;
    bus.packet_valid = pv;
    bus.fifo_full = ff;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask
  task automatic packet(input logic [7:0] h, input logic [7:0] p, input logic [7:0] par);
    drive("det", h, 1, 0);
    drive("lfd", p, 1, 0);
    drive("ld", p, 1, 0);
    drive("ld", par, 0, 0);
    drive("chk", 8'h00, 0, 0);
  endtask
  initial begin
    resetn = 1'b0;
    m_reset();
    @(negedge clk);
    drive("idle", 8'h00, 0, 0);
    drive("idle", 8'h00, 0, 0);
    check("reset_dout", bus.dout, 8'h00);
    check("reset_pd", {7'd0, bus.parity_done}, 8'h00);
    resetn = 1'b1;
    drive("idle", 8'h00, 0, 0);
    drive("det", 8'h05, 1, 0);
    drive("lfd", 8'hA3, 1, 0);
    check("good_hdr_out", bus.dout, 8'h05);
    drive("ld", 8'hA3, 1, 0);
    check("good_payload_out", bus.dout, 8'hA3);
    drive("ld", 8'hA6, 0, 0);
    check("good_pd", {7'd0, bus.parity_done}, 8'h01);
    check("good_lpv", {7'd0, bus.low_packet_valid}, 8'h01);
    drive("chk", 8'h00, 0, 0);
    check("good_err", {7'd0, bus.err}, 8'h00);
    check("good_lpv_clr", {7'd0, bus.low_packet_valid}, 8'h00);
    packet(8'h05, 8'hA3, 8'h00);
    check("bad_err", {7'd0, bus.err}, 8'h01);
    drive("det", 8'h05, 1, 0);
    check("bad_err_clr", {7'd0, bus.err}, 8'h00);
    drive("lfd", 8'hA3, 1, 0);
    drive("ld", 8'hA3, 1, 0);
    drive("ld", 8'h3C, 1, 1);
    check("full_hold", bus.dout, 8'hA3);
    drive("full", 8'h3C, 1, 1);
    check("full_state_hold", bus.dout, 8'hA3);
    drive("laf", 8'h3C, 1, 0);
    check("laf_dout", bus.dout, 8'h3C);
    drive("ld", 8'h9A, 0, 0);
    check("full_pd", {7'd0, bus.parity_done}, 8'h01);
    drive("chk", 8'h00, 0, 0);
    check("full_err", {7'd0, bus.err}, 8'h00);
    drive("det", 8'h06, 1, 0);
    drive("lfd", 8'h11, 1, 0);
    drive("ld", 8'h11, 1, 0);
    drive("ld", 8'h17, 0, 1);
    check("lpv_set", {7'd0, bus.low_packet_valid}, 8'h01);
    check("lpv_no_pd", {7'd0, bus.parity_done}, 8'h00);
    drive("full", 8'h17, 0, 1);
    drive("laf", 8'h17, 0, 0);
    check("laf_pd", {7'd0, bus.parity_done}, 8'h01);
    check("laf_ffs", bus.dout, 8'h17);
    drive("chk", 8'h00, 0, 0);
    check("lpv_clr", {7'd0, bus.low_packet_valid}, 8'h00);
    check("lpv_err", {7'd0, bus.err}, 8'h01);
    drive("det", 8'h07, 1, 0);
    check("inv_dout", bus.dout, 8'h17);
    drive("lfd", 8'h00, 1, 0);
    check("inv_hdr", bus.dout, 8'h06);
    drive("idle", 8'h00, 0, 0);
    drive("det", 8'h05, 1, 0);
    drive("lfd", 8'hA3, 1, 0);
    drive("ld", 8'hA3, 1, 0);
    check("pre_rst_dout", bus.dout, 8'hA3);
    #2 resetn = 1'b0;
    #1;
    check("rst_dout", bus.dout, 8'h00);
    check("rst_err", {7'd0, bus.err}, 8'h00);
    check("rst_pd", {7'd0, bus.parity_done}, 8'h00);
    check("rst_lpv", {7'd0, bus.low_packet_valid}, 8'h00);
    m_reset();
    @(negedge clk);
    drive("idle", 8'h00, 0, 0);
    resetn = 1'b1;
    drive("idle", 8'h00, 0, 0);
`ifdef ROUTER_REG_ERR_CNT_EN
    for (int i = 0; i < 300; i++) packet(8'h05, 8'hA3, 8'h00);
    drive("idle", 8'h00, 0, 0);
    check("err_cnt_sat", bus.err_cnt, 8'hFF);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
